// File: rtl/spu_ex_pkg.sv
// SPU execute stage: shared types, constants and ALU helpers.
// Imported by the EX stage, its multiply lane and the bench.
package spu_ex_pkg;

  localparam int WORD  = 32;
  localparam int LANES = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SF   = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_CEQ  = 4'd7,
    ALU_CGT  = 4'd8,
    ALU_MPY  = 4'd9,
    ALU_MPYA = 4'd10
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_e;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       regwrite;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic [6:0] dest;
  } ex_ctl_t;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == ALU_MPY) || (op == ALU_MPYA);
  endfunction

  function automatic logic is_rsvd(input logic [3:0] op);
    return op > ALU_MPYA;
  endfunction

  function automatic logic [WORD-1:0] alu_word(
    input logic [3:0]      op,
    input logic [WORD-1:0] a,
    input logic [WORD-1:0] b
  );
    logic [WORD-1:0] r;
    r = '0;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SF:  r = b - a;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      ALU_SHL: r = b[5] ? '0 : (a << b[4:0]);
      ALU_CEQ: r = {WORD{a == b}};
      ALU_CGT: r = {WORD{$signed(a) > $signed(b)}};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/spu_ex_if.sv
// ID/EX operand bundle in, EX/MEM register bundle out.
// slave = execute stage, master = pipeline around it.
interface spu_ex_if #(
  parameter int PC_BITSIZE = 11
);
  logic                  in_valid;
  logic                  mem_to_reg_in;
  logic                  regwrite_in;
  logic                  branch_in;
  logic                  memread_in;
  logic                  memwrite_in;
  logic                  alusrc_in;
  logic                  dest_sel_in;
  logic [3:0]            aluctl_in;
  logic [127:0]          rd1_in;
  logic [127:0]          rd2_in;
  logic [127:0]          rd3_in;
  logic [127:0]          imm_in;
  logic [PC_BITSIZE-1:0] pc8_in;
  logic [6:0]            rt_in;
  logic [6:0]            rrr_in;
  logic [6:0]            ra_in;
  logic [6:0]            rb_in;

  logic                  out_valid;
  logic                  out_mem_to_reg;
  logic                  out_regwrite;
  logic                  out_branch;
  logic                  out_memread;
  logic                  out_memwrite;
  logic [127:0]          out_result;
  logic [127:0]          out_store;
  logic [PC_BITSIZE-1:0] out_pc8;
  logic [6:0]            out_dest;

  modport master (
    output in_valid, mem_to_reg_in, regwrite_in,
    output branch_in, memread_in, memwrite_in,
    output alusrc_in, dest_sel_in, aluctl_in,
    output rd1_in, rd2_in, rd3_in, imm_in, pc8_in,
    output rt_in, rrr_in, ra_in, rb_in,
    input  out_valid, out_mem_to_reg, out_regwrite,
    input  out_branch, out_memread, out_memwrite,
    input  out_result, out_store, out_pc8, out_dest
  );

  modport slave (
    input  in_valid, mem_to_reg_in, regwrite_in,
    input  branch_in, memread_in, memwrite_in,
    input  alusrc_in, dest_sel_in, aluctl_in,
    input  rd1_in, rd2_in, rd3_in, imm_in, pc8_in,
    input  rt_in, rrr_in, ra_in, rb_in,
    output out_valid, out_mem_to_reg, out_regwrite,
    output out_branch, out_memread, out_memwrite,
    output out_result, out_store, out_pc8, out_dest
  );
endinterface

// File: rtl/spu_ex_mul_lane.sv
// One multiply lane: signed 16x16 product plus optional addend.
// Purely combinational; the EX stage sequences lanes over time.
module spu_ex_mul_lane
  import spu_ex_pkg::*;
(
  input  logic [15:0]     a,
  input  logic [15:0]     b,
  input  logic [WORD-1:0] c,
  input  logic            acc_en,
  output logic [WORD-1:0] p
);
  logic signed [WORD-1:0] prod;

  assign prod = $signed(a) * $signed(b);
  assign p    = prod + (acc_en ? c : '0);
endmodule

// File: rtl/spu_ex_stage.sv
// SPU execute stage with built-in EX/MEM register and lane-serial MPY.
// Define SPU_EX_FWD_EN to enable operand forwarding.
module spu_ex_stage
  import spu_ex_pkg::*;
#(
  parameter int PC_BITSIZE   = 11,
  parameter int MPY_LANES_PC = 1
) (
  input  logic          clk,
  input  logic          reset,
  spu_ex_if.slave       ex,
  input  logic          wb_we,
  input  logic [6:0]    wb_rt,
  input  logic [127:0]  wb_data,
  input  logic          flush_i,
  output logic          stall_o
);
  localparam logic [2:0] STEP = 3'(MPY_LANES_PC);

  ex_state_e             state_q, state_d;
  logic [2:0]            lane_q, lane_d;
  logic                  last;

  ex_ctl_t               out_ctl_q, ctl_d, iss_ctl;
  logic [127:0]          res_q, res_d;
  logic [127:0]          store_q, store_d;
  logic [PC_BITSIZE-1:0] pc8_q, pc8_d;
  logic                  data_ld;

  logic                  cap_ld;
  logic [63:0]           cap_a, cap_b, a_lo, b_lo;
  logic [127:0]          cap_c, cap_store;
  logic                  cap_acc;
  ex_ctl_t               cap_ctl;
  logic [PC_BITSIZE-1:0] cap_pc8;

  logic [127:0]          acc_q, mul_nxt;
  logic [127:0]          opa, opb_reg, opc, opb, alu_res;
  logic [3:0]            op;

  assign op = ex.aluctl_in;

`ifdef SPU_EX_FWD_EN
  function automatic logic [127:0] fwd(
    input logic [6:0]   src,
    input logic [127:0] rd
  );
    if (out_ctl_q.valid && out_ctl_q.regwrite &&
        out_ctl_q.dest == src)
      return res_q;
    else if (wb_we && wb_rt == src)
      return wb_data;
    else
      return rd;
  endfunction

  // RC of an RRR-form op sits in the rt field
  always_comb begin
    opa     = fwd(ex.ra_in, ex.rd1_in);
    opb_reg = fwd(ex.rb_in, ex.rd2_in);
    opc     = fwd(ex.rt_in, ex.rd3_in);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex.ra_in, ex.rb_in,
                        wb_we, wb_rt, wb_data};
  assign opa     = ex.rd1_in;
  assign opb_reg = ex.rd2_in;
  assign opc     = ex.rd3_in;
`endif

  assign opb = ex.alusrc_in ? ex.imm_in : opb_reg;

  // Per-word ALU and low-half extraction for multiply capture
  always_comb begin
    alu_res = '0;
    a_lo    = '0;
    b_lo    = '0;
    for (int w = 0; w < LANES; w++) begin
      alu_res[w*WORD +: WORD] =
        alu_word(op, opa[w*WORD +: WORD], opb[w*WORD +: WORD]);
      a_lo[w*16 +: 16] = opa[w*WORD +: 16];
      b_lo[w*16 +: 16] = opb[w*WORD +: 16];
    end
  end

  logic [WORD-1:0] lane_p   [MPY_LANES_PC];
  logic [1:0]      lane_idx [MPY_LANES_PC];

  for (genvar k = 0; k < MPY_LANES_PC; k++) begin : g_lane
    assign lane_idx[k] = lane_q[1:0] + 2'(k);
    spu_ex_mul_lane u_lane (
      .a      (cap_a[{lane_idx[k], 4'b0} +: 16]),
      .b      (cap_b[{lane_idx[k], 4'b0} +: 16]),
      .c      (cap_c[{lane_idx[k], 5'b0} +: WORD]),
      .acc_en (cap_acc),
      .p      (lane_p[k])
    );
  end

  // Merge this cycle's lane products into the partial result
  always_comb begin
    mul_nxt = acc_q;
    for (int k = 0; k < MPY_LANES_PC; k++)
      mul_nxt[{lane_idx[k], 5'b0} +: WORD] = lane_p[k];
  end

  assign last = (lane_q + STEP) == 3'(LANES);

  always_comb begin
    iss_ctl            = '0;
    iss_ctl.valid      = 1'b1;
    iss_ctl.mem_to_reg = ex.mem_to_reg_in;
    iss_ctl.regwrite   = ex.regwrite_in && !is_rsvd(op);
    iss_ctl.branch     = ex.branch_in;
    iss_ctl.memread    = ex.memread_in;
    iss_ctl.memwrite   = ex.memwrite_in;
    iss_ctl.dest       = ex.dest_sel_in ? ex.rrr_in : ex.rt_in;
  end

  // Next-state, stall and EX/MEM load selection
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    stall_o = 1'b0;
    cap_ld  = 1'b0;
    data_ld = 1'b0;
    ctl_d   = '0;
    res_d   = res_q;
    store_d = store_q;
    pc8_d   = pc8_q;
    case (state_q)
      IDLE: begin
        if (ex.in_valid) begin
          if (is_mul(op)) begin
            cap_ld  = 1'b1;
            stall_o = 1'b1;
            lane_d  = '0;
            state_d = MUL;
          end else begin
            data_ld = 1'b1;
            ctl_d   = iss_ctl;
            res_d   = alu_res;
            store_d = opb_reg;
            pc8_d   = ex.pc8_in;
          end
        end
      end
      MUL: begin
        lane_d  = lane_q + STEP;
        stall_o = !last;
        if (last) begin
          state_d = IDLE;
          data_ld = 1'b1;
          ctl_d   = cap_ctl;
          res_d   = mul_nxt;
          store_d = cap_store;
          pc8_d   = cap_pc8;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      lane_d  = '0;
      stall_o = 1'b0;
      cap_ld  = 1'b0;
      data_ld = 1'b0;
      ctl_d   = '0;
    end
  end

  // State, operand capture and EX/MEM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      out_ctl_q <= '0;
      res_q     <= '0;
      store_q   <= '0;
      pc8_q     <= '0;
      cap_a     <= '0;
      cap_b     <= '0;
      cap_c     <= '0;
      cap_acc   <= 1'b0;
      cap_ctl   <= '0;
      cap_pc8   <= '0;
      cap_store <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      out_ctl_q <= ctl_d;
      if (data_ld) begin
        res_q   <= res_d;
        store_q <= store_d;
        pc8_q   <= pc8_d;
      end
      if (cap_ld) begin
        cap_a     <= a_lo;
        cap_b     <= b_lo;
        cap_c     <= opc;
        cap_acc   <= (op == ALU_MPYA);
        cap_ctl   <= iss_ctl;
        cap_pc8   <= ex.pc8_in;
        cap_store <= opb_reg;
      end
      if (state_q == MUL)
        acc_q <= mul_nxt;
    end
  end

  assign ex.out_valid      = out_ctl_q.valid;
  assign ex.out_mem_to_reg = out_ctl_q.mem_to_reg;
  assign ex.out_regwrite   = out_ctl_q.regwrite;
  assign ex.out_branch     = out_ctl_q.branch;
  assign ex.out_memread    = out_ctl_q.memread;
  assign ex.out_memwrite   = out_ctl_q.memwrite;
  assign ex.out_dest       = out_ctl_q.dest;
  assign ex.out_result     = res_q;
  assign ex.out_store      = store_q;
  assign ex.out_pc8        = pc8_q;
endmodule

// File: tb/tb_spu_ex_stage.sv
// Directed bench for spu_ex_stage (1-lane and 4-lane multiply builds).
// Expected values are hand-computed constants.
module tb_spu_ex_stage;
  import spu_ex_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         flush, wb_we;
  logic [6:0]   wb_rt;
  logic [127:0] wb_data;
  logic         stall1, stall4;

  logic         v, asrc, dsel;
  logic [3:0]   op;
  logic [127:0] a, b, c, imm;
  logic [10:0]  pc8;
  logic [6:0]   rt, rrr, ra, rb;

  int n_run  = 0;
  int n_fail = 0;

  spu_ex_if #(.PC_BITSIZE(11)) if1 ();
  spu_ex_if #(.PC_BITSIZE(11)) if4 ();

  assign if1.in_valid = v;      assign if4.in_valid = v;
  assign if1.mem_to_reg_in = 1'b0;
  assign if4.mem_to_reg_in = 1'b0;
  assign if1.regwrite_in = 1'b1;
  assign if4.regwrite_in = 1'b1;
  assign if1.branch_in = 1'b0;  assign if4.branch_in = 1'b0;
  assign if1.memread_in = 1'b0; assign if4.memread_in = 1'b0;
  assign if1.memwrite_in = 1'b0;
  assign if4.memwrite_in = 1'b0;
  assign if1.alusrc_in = asrc;  assign if4.alusrc_in = asrc;
  assign if1.dest_sel_in = dsel; assign if4.dest_sel_in = dsel;
  assign if1.aluctl_in = op;    assign if4.aluctl_in = op;
  assign if1.rd1_in = a;        assign if4.rd1_in = a;
  assign if1.rd2_in = b;        assign if4.rd2_in = b;
  assign if1.rd3_in = c;        assign if4.rd3_in = c;
  assign if1.imm_in = imm;      assign if4.imm_in = imm;
  assign if1.pc8_in = pc8;      assign if4.pc8_in = pc8;
  assign if1.rt_in = rt;        assign if4.rt_in = rt;
  assign if1.rrr_in = rrr;      assign if4.rrr_in = rrr;
  assign if1.ra_in = ra;        assign if4.ra_in = ra;
  assign if1.rb_in = rb;        assign if4.rb_in = rb;

  spu_ex_stage #(.PC_BITSIZE(11), .MPY_LANES_PC(1)) u_dut (
    .clk(clk), .reset(reset), .ex(if1),
    .wb_we(wb_we), .wb_rt(wb_rt), .wb_data(wb_data),
    .flush_i(flush), .stall_o(stall1)
  );

  spu_ex_stage #(.PC_BITSIZE(11), .MPY_LANES_PC(4)) u_dut4 (
    .clk(clk), .reset(reset), .ex(if4),
    .wb_we(wb_we), .wb_rt(wb_rt), .wb_data(wb_data),
    .flush_i(flush), .stall_o(stall4)
  );

  localparam logic [127:0] VA = {32'h0000_00F0, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h1234_5678};
  localparam logic [127:0] VB = {32'h0000_0004, 32'h0000_0020,
                                 32'h0000_0001, 32'h1234_5678};
  localparam logic [127:0] MA = {4{32'hABCD_FFFE}};
  localparam logic [127:0] MB = {4{32'h1234_0003}};

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v = 1'b0; asrc = 1'b0; dsel = 1'b0; op = 4'd0;
    a = '0; b = '0; c = '0; imm = '0; pc8 = 11'h123;
    rt = 7'd0; rrr = 7'd0; ra = 7'd0; rb = 7'd0;
  endtask

  task automatic issue(input logic [3:0] o,
                       input logic [127:0] ia, ib, ic,
                       input logic [6:0] irt, ira, irb);
    v = 1'b1; op = o; a = ia; b = ib; c = ic;
    rt = irt; ra = ira; rb = irb;
  endtask

  task automatic op_chk(input string tag, input logic [3:0] o,
                        input logic [127:0] exp,
                        input logic exp_rw);
    issue(o, VA, VB, '0, 7'd9, 7'd1, 7'd2);
    tick();
    check(tag, if1.out_result, exp);
    check({tag, "_rw"}, 128'(if1.out_regwrite), 128'(exp_rw));
  endtask

  initial begin
    flush = 1'b0; wb_we = 1'b0; wb_rt = '0; wb_data = '0;
    idle();
    tick(); tick();
    check("rst_valid", 128'(if1.out_valid), 128'(0));
    check("rst_result", if1.out_result, '0);
    check("rst_dest", 128'(if1.out_dest), 128'(0));
    check("rst_stall", 128'(stall1), 128'(0));
    reset = 1'b0;

    issue(ALU_ADD, {4{32'h7FFF_FFFF}}, {4{32'h1}}, '0,
          7'd5, 7'd1, 7'd2);
    #1 check("add_stall", 128'(stall1), 128'(0));
    tick();
    check("add_valid", 128'(if1.out_valid), 128'(1));
    check("add_res", if1.out_result, {4{32'h8000_0000}});
    check("add_dest", 128'(if1.out_dest), 128'(5));
    check("add_pc8", 128'(if1.out_pc8), 128'(11'h123));

    op_chk("sf", ALU_SF, {32'hFFFF_FF14, 32'h0000_0021,
           32'h8000_0001, 32'h0}, 1'b1);
    op_chk("and", ALU_AND, {32'h0, 32'h20, 32'h0,
           32'h1234_5678}, 1'b1);
    op_chk("xor", ALU_XOR, {32'hF4, 32'hFFFF_FFDF,
           32'h8000_0001, 32'h0}, 1'b1);
    op_chk("nor", ALU_NOR, {32'hFFFF_FF0B, 32'h0,
           32'h7FFF_FFFE, 32'hEDCB_A987}, 1'b1);
    op_chk("shl", ALU_SHL, {32'hF00, 32'h0, 32'h0, 32'h0}, 1'b1);
    op_chk("ceq", ALU_CEQ, {32'h0, 32'h0, 32'h0,
           32'hFFFF_FFFF}, 1'b1);
    op_chk("cgt", ALU_CGT, {32'hFFFF_FFFF, 32'h0, 32'h0,
           32'h0}, 1'b1);
    op_chk("rsvd", 4'd11, '0, 1'b0);

    issue(ALU_ADD, VA, {4{32'hDEAD_BEEF}}, '0, 7'd3, 7'd1, 7'd2);
    asrc = 1'b1; imm = {4{32'd10}};
    tick();
    check("imm_res", if1.out_result, {32'hFA, 32'h9,
          32'h8000_000A, 32'h1234_5682});
    check("imm_store", if1.out_store, {4{32'hDEAD_BEEF}});
    idle();
    tick();
    check("bub_valid", 128'(if1.out_valid), 128'(0));
    check("bub_hold", if1.out_result, {32'hFA, 32'h9,
          32'h8000_000A, 32'h1234_5682});

    issue(ALU_MPY, MA, MB, '0, 7'd12, 7'd1, 7'd2);
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("mpy_stall%0d", i),
               128'(stall1), 128'(1));
      tick();
      check($sformatf("mpy_bub%0d", i),
            128'(if1.out_valid), 128'(0));
    end
    #1 check("mpy_stall_last", 128'(stall1), 128'(0));
    issue(ALU_ADD, {4{32'd7}}, {4{32'd8}}, '0, 7'd4, 7'd1, 7'd2);
    tick();
    check("mpy_valid", 128'(if1.out_valid), 128'(1));
    check("mpy_res", if1.out_result, {4{32'hFFFF_FFFA}});
    check("mpy_dest", 128'(if1.out_dest), 128'(12));
    tick();
    check("mpy_next", if1.out_result, {4{32'd15}});

    reset = 1'b1; idle(); tick(); reset = 1'b0;
    issue(ALU_MPYA, {4{32'd2}}, {4{32'd3}}, {4{32'hFFFF_FFFF}},
          7'd8, 7'd1, 7'd2);
    #1 check("mpya4_stall0", 128'(stall4), 128'(1));
    tick();
    check("mpya4_bub", 128'(if4.out_valid), 128'(0));
    check("mpya4_stall1", 128'(stall4), 128'(0));
    idle();
    tick();
    check("mpya4_valid", 128'(if4.out_valid), 128'(1));
    check("mpya4_res", if4.out_result, {4{32'd5}});

    reset = 1'b1; idle(); tick(); reset = 1'b0;
    issue(ALU_MPY, MA, MB, '0, 7'd12, 7'd1, 7'd2);
    tick(); tick(); tick();
    check("fl_pre_stall", 128'(stall1), 128'(1));
    flush = 1'b1;
    #1 check("fl_stall", 128'(stall1), 128'(0));
    tick();
    flush = 1'b0; idle();
    check("fl_valid", 128'(if1.out_valid), 128'(0));
    check("fl_rw", 128'(if1.out_regwrite), 128'(0));
    #1 check("fl_stall_after", 128'(stall1), 128'(0));
    issue(ALU_ADD, {4{32'd1}}, {4{32'd1}}, '0, 7'd5, 7'd1, 7'd2);
    tick();
    check("fl_add", if1.out_result, {4{32'd2}});

    issue(ALU_MPY, MA, MB, '0, 7'd12, 7'd1, 7'd2);
    tick(); tick();
    reset = 1'b1; idle();
    tick();
    reset = 1'b0;
    check("rm_valid", 128'(if1.out_valid), 128'(0));
    check("rm_res", if1.out_result, '0);
    #1 check("rm_stall", 128'(stall1), 128'(0));
    issue(ALU_ADD, {4{32'd4}}, {4{32'd5}}, '0, 7'd5, 7'd1, 7'd2);
    tick();
    check("rm_add", if1.out_result, {4{32'd9}});

    issue(ALU_ADD, {4{32'd1}}, {4{32'd2}}, '0, 7'd5, 7'd1, 7'd2);
    tick();
    issue(ALU_ADD, {4{32'd100}}, {4{32'd100}}, '0,
          7'd6, 7'd5, 7'd5);
    wb_we = 1'b1; wb_rt = 7'd5; wb_data = {4{32'd50}};
    tick();
`ifdef SPU_EX_FWD_EN
    check("fwd_exmem", if1.out_result, {4{32'd6}});
`else
    check("fwd_exmem", if1.out_result, {4{32'd200}});
`endif
    issue(ALU_ADD, {4{32'd100}}, {4{32'd1}}, '0,
          7'd7, 7'd5, 7'd7);
    tick();
`ifdef SPU_EX_FWD_EN
    check("fwd_wb", if1.out_result, {4{32'd51}});
`else
    check("fwd_wb", if1.out_result, {4{32'd101}});
`endif
    wb_we = 1'b0; idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
